// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and width helpers for the stream round-robin arbiter slice.
package stream_rr_arbiter_pkg;

   typedef enum logic {
      LOCK_OPEN = 1'b0,
      LOCK_HELD = 1'b1
   } lock_state_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Bundle of the N-to-1 stream handshake seen by the arbiter (slave) and its environment (master).
interface stream_rr_arbiter_if
   import stream_rr_arbiter_pkg::*;
#(
   parameter int unsigned NumInp    = 4,
   parameter type         payload_t = logic,
   parameter int unsigned IdxWidth  = idx_width(NumInp)
);

   payload_t              payload_i [NumInp];
   logic [NumInp-1:0]     valid_i;
   logic [NumInp-1:0]     ready_o;
   payload_t              payload_o;
   logic                  valid_o;
   logic                  ready_i;
   logic [IdxWidth-1:0]   idx_o;

   modport slave (
      input  payload_i, valid_i, ready_i,
      output ready_o, payload_o, valid_o, idx_o
   );

   modport master (
      output payload_i, valid_i, ready_i,
      input  ready_o, payload_o, valid_o, idx_o
   );

endinterface

// File: rtl/stream_rr_arbiter_rr_select.sv
// Combinational circular first-set search: rotate by start, find lowest set bit, un-rotate.
module rr_select
   import stream_rr_arbiter_pkg::*;
#(
   parameter int unsigned NumInp   = 4,
   parameter int unsigned IdxWidth = idx_width(NumInp)
) (
   input  logic [NumInp-1:0]   req_i,
   input  logic [IdxWidth-1:0] start_i,
   output logic [NumInp-1:0]   gnt_o,
   output logic [IdxWidth-1:0] idx_o,
   output logic                any_o
);

   logic [2*NumInp-1:0] req_dbl;
   logic [NumInp-1:0]   req_rot;
   logic [IdxWidth-1:0] ofs;
   logic [IdxWidth:0]   sum;

   always_comb begin
      req_dbl = {req_i, req_i} >> start_i;
      req_rot = req_dbl[NumInp-1:0];
      ofs     = '0;
      any_o   = 1'b0;
      // Scan downwards so the lowest set offset wins.
      for (int unsigned k = NumInp; k > 0; k--) begin
         if (req_rot[k-1]) begin
            ofs   = IdxWidth'(k - 1);
            any_o = 1'b1;
         end
      end
      sum = {1'b0, start_i} + {1'b0, ofs};
      if (sum >= (IdxWidth+1)'(NumInp)) begin
         sum = sum - (IdxWidth+1)'(NumInp);
      end
      idx_o = sum[IdxWidth-1:0];
      gnt_o = '0;
      for (int unsigned i = 0; i < NumInp; i++) begin
         gnt_o[i] = any_o && (idx_o == IdxWidth'(i));
      end
   end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter with a bounded burst allowance and grant lock while stalled.
module stream_rr_arbiter
   import stream_rr_arbiter_pkg::*;
#(
   parameter int unsigned NumInp    = 4,
   parameter int unsigned MaxGrants = 1,
   parameter type         payload_t = logic,
   parameter int unsigned IdxWidth  = idx_width(NumInp)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   stream_rr_arbiter_if.slave bus
);

   localparam int unsigned CntWidth = $clog2(MaxGrants + 1);

   lock_state_e         lock_q, lock_d;
   logic [IdxWidth-1:0] lock_idx_q, lock_idx_d;
   logic [IdxWidth-1:0] rr_q, rr_d;
   logic [CntWidth-1:0] cnt_q, cnt_d;

   logic [NumInp-1:0]   scan_gnt, sel_gnt;
   logic [IdxWidth-1:0] scan_idx, sel;
   logic                scan_any;
   logic                valid_out, handshake;
   payload_t            payload_sel;

   rr_select #(
      .NumInp   (NumInp),
      .IdxWidth (IdxWidth)
   ) i_rr_select (
      .req_i   (bus.valid_i),
      .start_i (rr_q),
      .gnt_o   (scan_gnt),
      .idx_o   (scan_idx),
      .any_o   (scan_any)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lock_q     <= LOCK_OPEN;
         lock_idx_q <= '0;
         rr_q       <= '0;
         cnt_q      <= '0;
      end else begin
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         rr_q       <= rr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Priority only moves on a handshake; a stall freezes the grant on sel.
   always_comb begin
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      if (handshake) begin
         lock_d = LOCK_OPEN;
         cnt_d  = (sel == rr_q) ? cnt_q + 1'b1 : CntWidth'(1);
         if (cnt_d == CntWidth'(MaxGrants)) begin
            rr_d  = (sel == IdxWidth'(NumInp - 1)) ? '0 : sel + 1'b1;
            cnt_d = '0;
         end else begin
            rr_d = sel;
         end
      end else if (valid_out) begin
         lock_d     = LOCK_HELD;
         lock_idx_d = sel;
      end
   end

   always_comb begin
      sel     = scan_idx;
      sel_gnt = scan_gnt;
      if (lock_q == LOCK_HELD) begin
         sel = lock_idx_q;
         for (int unsigned i = 0; i < NumInp; i++) begin
            sel_gnt[i] = (lock_idx_q == IdxWidth'(i));
         end
      end
      valid_out   = scan_any && bus.valid_i[sel];
      handshake   = valid_out && bus.ready_i;
      payload_sel = bus.payload_i[sel];
   end

   assign bus.valid_o   = valid_out;
   assign bus.payload_o = payload_sel;
   assign bus.idx_o     = scan_any ? sel : rr_q;
   assign bus.ready_o   = sel_gnt & {NumInp{handshake}};

   lock_hold_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (lock_q == LOCK_HELD) |-> bus.valid_i[lock_idx_q]);

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random traffic against a rule-level model.
module tb_stream_rr_arbiter;

   typedef logic [7:0] byte_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   stream_rr_arbiter_if #(.NumInp(4), .payload_t(byte_t)) bus2 ();
   stream_rr_arbiter_if #(.NumInp(4), .payload_t(byte_t)) bus1 ();

   stream_rr_arbiter #(.NumInp(4), .MaxGrants(2), .payload_t(byte_t)) dut2 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus2)
   );

   stream_rr_arbiter #(.NumInp(4), .MaxGrants(1), .payload_t(byte_t)) dut1 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Model state per DUT (index 0: MaxGrants=2, index 1: MaxGrants=1).
   int unsigned m_ptr [2];
   int unsigned m_streak [2];
   int unsigned m_hold_idx [2];
   bit          m_held [2];
   int unsigned m_max [2];
   byte_t       pay [2][4];
   logic [3:0]  vin [2];
   logic        rin [2];

   function automatic void m_reset();
      for (int d = 0; d < 2; d++) begin
         m_ptr[d] = 0; m_streak[d] = 0; m_hold_idx[d] = 0; m_held[d] = 1'b0;
      end
   endfunction

   function automatic int unsigned m_winner(input int d);
      if (m_held[d]) return m_hold_idx[d];
      for (int unsigned k = 0; k < 4; k++)
         if (vin[d][(m_ptr[d] + k) % 4]) return (m_ptr[d] + k) % 4;
      return m_ptr[d];
   endfunction

   // Packed as {idx[1:0], valid, ready[3:0], payload[7:0]}.
   function automatic logic [14:0] m_expect(input int d);
      int unsigned w;
      logic any, ev;
      logic [3:0] er;
      logic [1:0] ei;
      w   = m_winner(d);
      any = |vin[d];
      ev  = any && vin[d][w];
      ei  = any ? 2'(w) : 2'(m_ptr[d]);
      er  = (ev && rin[d]) ? 4'(1 << w) : 4'b0000;
      return {ei, ev, er, pay[d][w]};
   endfunction

   function automatic void m_step(input int d);
      int unsigned w;
      logic ev;
      w  = m_winner(d);
      ev = (|vin[d]) && vin[d][w];
      if (ev && rin[d]) begin
         m_streak[d] = (w == m_ptr[d]) ? m_streak[d] + 1 : 1;
         if (m_streak[d] == m_max[d]) begin
            m_ptr[d] = (w + 1) % 4;
            m_streak[d] = 0;
         end else begin
            m_ptr[d] = w;
         end
         m_held[d] = 1'b0;
      end else if (ev) begin
         m_held[d] = 1'b1;
         m_hold_idx[d] = w;
      end
   endfunction

   function automatic logic [14:0] dut_out(input int d);
      if (d == 0) return {bus2.idx_o, bus2.valid_o, bus2.ready_o, bus2.payload_o};
      return {bus1.idx_o, bus1.valid_o, bus1.ready_o, bus1.payload_o};
   endfunction

   function automatic string fmt(input logic [14:0] x);
      return $sformatf("idx=%0d v=%b rdy=%b pay=%h", x[14:13], x[12], x[11:8], x[7:0]);
   endfunction

   task automatic drive(input int d, input logic [3:0] v, input logic r);
      vin[d] = v;
      rin[d] = r;
      for (int i = 0; i < 4; i++) begin
         if (d == 0) bus2.payload_i[i] = pay[0][i];
         else        bus1.payload_i[i] = pay[1][i];
      end
      if (d == 0) begin bus2.valid_i = v; bus2.ready_i = r; end
      else        begin bus1.valid_i = v; bus1.ready_i = r; end
   endtask

   task automatic test_reset;
      logic [14:0] a, e;
      rst = 1'b1;
      m_reset();
      drive(0, 4'b0000, 1'b1);
      drive(1, 4'b0000, 1'b1);
      @(negedge clk);
      a = dut_out(0);
      n_checks++;
      if (a[14:8] !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_idle: got %s, expected idx=0 v=0 rdy=0000", fmt(a));
      end
      // Outputs stay combinational while reset is held.
      drive(0, 4'b0110, 1'b1);
      #1;
      a = dut_out(0);
      e = m_expect(0);
      n_checks++;
      if (a !== e || a[14:13] !== 2'd1) begin
         n_fail++;
         $display("FAIL reset_comb: got %s, expected %s", fmt(a), fmt(e));
      end
      drive(0, 4'b0000, 1'b1);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_burst;
      logic [14:0] a, e;
      int seq [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < 4; i++) pay[0][i] = byte_t'($urandom);
         drive(0, 4'b1111, 1'b1);
         @(negedge clk);
         a = dut_out(0);
         e = m_expect(0);
         n_checks++;
         if (a !== e || 32'(a[14:13]) != seq[c]) begin
            n_fail++;
            $display("FAIL burst c%0d: got %s, expected %s (idx %0d)", c, fmt(a), fmt(e), seq[c]);
         end
         m_step(0);
         @(posedge clk); #1;
      end
      drive(0, 4'b0000, 1'b1);
      @(negedge clk);
      a = dut_out(0);
      n_checks++;
      if (a[14:13] !== 2'd0 || a[12] !== 1'b0) begin
         n_fail++;
         $display("FAIL burst_wrap: got %s, expected idx=0 v=0", fmt(a));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stall;
      logic [14:0] a, e;
      logic [3:0] want_rdy;
      pay[0][1] = 8'hA5;
      for (int c = 0; c < 6; c++) begin
         pay[0][3] = byte_t'($urandom);
         pay[0][0] = byte_t'($urandom);
         drive(0, 4'b1010, (c >= 3));
         @(negedge clk);
         a = dut_out(0);
         e = m_expect(0);
         want_rdy = (c == 3 || c == 4) ? 4'b0010 : (c == 5) ? 4'b1000 : 4'b0000;
         n_checks++;
         if (a !== e || a[11:8] !== want_rdy || (c <= 4 && a[7:0] !== 8'hA5)) begin
            n_fail++;
            $display("FAIL stall c%0d: got %s, expected %s", c, fmt(a), fmt(e));
         end
         m_step(0);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_late_request;
      logic [14:0] a, e;
      logic [3:0] v;
      for (int c = 0; c < 5; c++) begin
         v = (c == 0) ? 4'b1000 : 4'b1001;
         drive(0, v, (c >= 3));
         @(negedge clk);
         a = dut_out(0);
         e = m_expect(0);
         n_checks++;
         if (a !== e || a[14:13] !== ((c < 4) ? 2'd3 : 2'd0)) begin
            n_fail++;
            $display("FAIL late_req c%0d: got %s, expected %s", c, fmt(a), fmt(e));
         end
         m_step(0);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_pure_rr;
      logic [14:0] a, e;
      for (int c = 0; c < 6; c++) begin
         pay[1][0] = byte_t'($urandom);
         pay[1][3] = byte_t'($urandom);
         drive(1, 4'b1001, 1'b1);
         @(negedge clk);
         a = dut_out(1);
         e = m_expect(1);
         n_checks++;
         if (a !== e || a[14:13] !== ((c % 2 == 0) ? 2'd0 : 2'd3)) begin
            n_fail++;
            $display("FAIL pure_rr c%0d: got %s, expected %s", c, fmt(a), fmt(e));
         end
         m_step(1);
         @(posedge clk); #1;
      end
      drive(1, 4'b0000, 1'b1);
   endtask

   task automatic test_async_reset;
      logic [14:0] a, e;
      drive(0, 4'b0100, 1'b0);
      @(negedge clk);
      m_step(0);
      @(posedge clk); #1;
      #2 rst = 1'b1;
      m_reset();
      drive(0, 4'b0110, 1'b0);
      #1;
      a = dut_out(0);
      e = m_expect(0);
      n_checks++;
      if (a !== e || a[14:13] !== 2'd1) begin
         n_fail++;
         $display("FAIL async_reset_lock: got %s, expected %s", fmt(a), fmt(e));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(0, 4'b0110, 1'b1);
      @(negedge clk);
      a = dut_out(0);
      e = m_expect(0);
      n_checks++;
      if (a !== e || a[14:13] !== 2'd1 || a[11:8] !== 4'b0010) begin
         n_fail++;
         $display("FAIL async_reset_release: got %s, expected %s", fmt(a), fmt(e));
      end
      m_step(0);
      @(posedge clk); #1;
   endtask

   task automatic test_idle;
      logic [14:0] a, e;
      for (int c = 0; c < 6; c++) begin
         drive(0, (c < 4) ? 4'b0000 : 4'b1111, (c < 4) ? logic'($urandom_range(0, 1)) : 1'b1);
         @(negedge clk);
         a = dut_out(0);
         e = m_expect(0);
         n_checks++;
         if (a !== e || (c < 4 && a[12:8] !== 5'b0) || (c >= 4 && 32'(a[14:13]) != c - 3)) begin
            n_fail++;
            $display("FAIL idle c%0d: got %s, expected %s", c, fmt(a), fmt(e));
         end
         m_step(0);
         @(posedge clk); #1;
      end
   endtask

   task automatic test_random;
      logic [14:0] a, e;
      logic [3:0] v;
      for (int c = 0; c < 200; c++) begin
         for (int d = 0; d < 2; d++) begin
            v = 4'($urandom);
            for (int i = 0; i < 4; i++)
               if (!(m_held[d] && m_hold_idx[d] == i)) pay[d][i] = byte_t'($urandom);
            if (m_held[d]) v[m_hold_idx[d]] = 1'b1;
            drive(d, v, ($urandom_range(0, 3) != 0));
         end
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            a = dut_out(d);
            e = m_expect(d);
            n_checks++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL random dut%0d c%0d: got %s, expected %s", d, c, fmt(a), fmt(e));
            end
            m_step(d);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      m_max[0] = 2;
      m_max[1] = 1;
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) pay[d][i] = byte_t'($urandom);
      test_reset();
      test_burst();
      test_stall();
      test_late_request();
      test_pure_rr();
      test_async_reset();
      test_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
